// File: rtl/park_gate_ctrl_if.sv
// rtl/park_gate_ctrl_if.sv - entry/exit lane request and acknowledge handshake bundle
interface park_gate_ctrl_if;
  logic ent_req;
  logic ent_is_uni;
  logic ent_ack;
  logic ent_grant;
  logic ext_req;
  logic ext_is_uni;
  logic ext_ack;

  modport master (
    output ent_req, ent_is_uni, ext_req, ext_is_uni,
    input  ent_ack, ent_grant, ext_ack
  );

  modport slave (
    input  ent_req, ent_is_uni, ext_req, ext_is_uni,
    output ent_ack, ent_grant, ext_ack
  );
endinterface

// File: rtl/park_gate_ctrl.sv
// rtl/park_gate_ctrl.sv - two-lane parking gate arbiter, hourly capacity check, occupancy and barrier timer
// Optional PARK_REJECT_STATS_EN adds a saturating refused-entry counter port reject_count.
module park_gate_ctrl #(
  parameter int TOTAL_CAP   = 700,
  parameter int OPEN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hour_tick,
  park_gate_ctrl_if.slave      lanes,
  output logic                 gate_open,
  output logic [4:0]           hour,
  output logic [9:0]           uni_count,
  output logic [9:0]           gen_count,
  output logic                 uni_full,
  output logic                 gen_full
`ifdef PARK_REJECT_STATS_EN
  , output logic [15:0]        reject_count
`endif
);

  localparam int OW = $clog2(OPEN_CYCLES + 1);
  localparam logic [9:0] CAP_TOT = 10'(TOTAL_CAP);

  typedef enum logic [1:0] {IDLE, SERVE, OPEN} state_t;
  state_t state, state_d;

  logic          lat_ent, lat_ent_d;
  logic          lat_uni, lat_uni_d;
  logic          rr_ent_next, rr_ent_next_d;
  logic [OW-1:0] open_cnt;
  logic          ent_ack_q, ent_grant_q, ext_ack_q;
  logic          ent_ack_d, ent_grant_d, ext_ack_d;
  logic          inc, dec, open_load, refuse;
  logic [9:0]    uni_cap, gen_cap, tgt_count;
  logic          has_space;

  always_comb begin
    if (hour < 5'd13)       uni_cap = 10'd500;
    else if (hour == 5'd13) uni_cap = 10'd450;
    else if (hour == 5'd14) uni_cap = 10'd400;
    else if (hour == 5'd15) uni_cap = 10'd350;
    else                    uni_cap = 10'd200;
  end

  assign gen_cap   = CAP_TOT - uni_cap;
  assign uni_full  = (uni_count >= uni_cap);
  assign gen_full  = (gen_count >= gen_cap);
  assign tgt_count = lat_uni ? uni_count : gen_count;
  assign has_space = lat_uni ? (uni_count < uni_cap) : (gen_count < gen_cap);
  assign gate_open = (state == OPEN);

  assign lanes.ent_ack   = ent_ack_q;
  assign lanes.ent_grant = ent_grant_q;
  assign lanes.ext_ack   = ext_ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d       = state;
    lat_ent_d     = lat_ent;
    lat_uni_d     = lat_uni;
    rr_ent_next_d = rr_ent_next;
    inc           = 1'b0;
    dec           = 1'b0;
    open_load     = 1'b0;
    refuse        = 1'b0;
    ent_ack_d     = 1'b0;
    ent_grant_d   = 1'b0;
    ext_ack_d     = 1'b0;
    case (state)
      IDLE: begin
        // On contention the lane that was not served last wins; the other keeps its level.
        if (lanes.ent_req && (!lanes.ext_req || rr_ent_next)) begin
          lat_ent_d     = 1'b1;
          lat_uni_d     = lanes.ent_is_uni;
          rr_ent_next_d = 1'b0;
          state_d       = SERVE;
        end else if (lanes.ext_req) begin
          lat_ent_d     = 1'b0;
          lat_uni_d     = lanes.ext_is_uni;
          rr_ent_next_d = 1'b1;
          state_d       = SERVE;
        end
      end
      SERVE: begin
        if (lat_ent) begin
          ent_ack_d = 1'b1;
          if (has_space) begin
            inc         = 1'b1;
            ent_grant_d = 1'b1;
            open_load   = 1'b1;
            state_d     = OPEN;
          end else begin
            refuse  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          ext_ack_d = 1'b1;
          if (tgt_count != 10'd0) begin
            dec       = 1'b1;
            open_load = 1'b1;
            state_d   = OPEN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OPEN: begin
        if (open_cnt == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_ent     <= 1'b0;
      lat_uni     <= 1'b0;
      rr_ent_next <= 1'b1;
      open_cnt    <= '0;
      ent_ack_q   <= 1'b0;
      ent_grant_q <= 1'b0;
      ext_ack_q   <= 1'b0;
      uni_count   <= 10'd0;
      gen_count   <= 10'd0;
      hour        <= 5'd0;
    end else begin
      lat_ent     <= lat_ent_d;
      lat_uni     <= lat_uni_d;
      rr_ent_next <= rr_ent_next_d;
      ent_ack_q   <= ent_ack_d;
      ent_grant_q <= ent_grant_d;
      ext_ack_q   <= ext_ack_d;
      if (open_load)                           open_cnt <= OW'(OPEN_CYCLES - 1);
      else if (state == OPEN && open_cnt != '0) open_cnt <= open_cnt - 1'b1;
      if (inc &&  lat_uni) uni_count <= uni_count + 10'd1;
      if (inc && !lat_uni) gen_count <= gen_count + 10'd1;
      if (dec &&  lat_uni) uni_count <= uni_count - 10'd1;
      if (dec && !lat_uni) gen_count <= gen_count - 10'd1;
      if (hour_tick) hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end

`ifdef PARK_REJECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                reject_count <= 16'd0;
    else if (refuse && reject_count != 16'hFFFF) reject_count <= reject_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// tb/tb_park_gate_ctrl.sv - directed self-checking bench for park_gate_ctrl
module tb_park_gate_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hour_tick = 1'b0;
  logic       gate_open;
  logic [4:0] hour;
  logic [9:0] uni_count, gen_count;
  logic       uni_full, gen_full;
`ifdef PARK_REJECT_STATS_EN
  logic [15:0] reject_count;
`endif
  int checks = 0;
  int errors = 0;

  park_gate_ctrl_if lanes();

  park_gate_ctrl #(.TOTAL_CAP(700), .OPEN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .hour_tick(hour_tick), .lanes(lanes),
    .gate_open(gate_open), .hour(hour), .uni_count(uni_count), .gen_count(gen_count),
    .uni_full(uni_full), .gen_full(gen_full)
`ifdef PARK_REJECT_STATS_EN
    , .reject_count(reject_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
  endtask

  task automatic wait_ack(output logic ea, output logic eg, output logic xa, output int cyc);
    ea = 1'b0; eg = 1'b0; xa = 1'b0; cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (lanes.ent_ack || lanes.ext_ack) break;
    end
    ea = lanes.ent_ack; eg = lanes.ent_grant; xa = lanes.ext_ack;
    chk("ack_seen", {31'd0, ea | xa}, 32'd1);
  endtask

  task automatic wait_closed();
    for (int i = 0; i < 20; i++) begin
      if (!gate_open) break;
      @(negedge clk);
    end
  endtask

  task automatic serve(input bit ent, input bit uni, output logic grant);
    logic ea, xa;
    int cyc;
    if (ent) begin lanes.ent_req = 1'b1; lanes.ent_is_uni = uni; end
    else     begin lanes.ext_req = 1'b1; lanes.ext_is_uni = uni; end
    wait_ack(ea, grant, xa, cyc);
    lanes.ent_req = 1'b0;
    lanes.ext_req = 1'b0;
    wait_closed();
  endtask

  initial begin
    logic ea, eg, xa, g;
    int cyc, n;
    lanes.ent_req = 0; lanes.ent_is_uni = 0; lanes.ext_req = 0; lanes.ext_is_uni = 0;

    // reset state
    #2;
    chk("rst_gate", {31'd0, gate_open}, 0);
    chk("rst_hour", {27'd0, hour}, 0);
    chk("rst_uni", {22'd0, uni_count}, 0);
    chk("rst_ack", {31'd0, lanes.ent_ack}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // reset mid-OPEN with counts 5/3
    repeat (3) tick();
    for (int i = 0; i < 5; i++) serve(1, 1, g);
    for (int i = 0; i < 2; i++) serve(1, 0, g);
    lanes.ent_req = 1'b1; lanes.ent_is_uni = 1'b0;
    wait_ack(ea, eg, xa, cyc);
    lanes.ent_req = 1'b0;
    chk("t1_gate_before", {31'd0, gate_open}, 1);
    chk("t1_uni_before", {22'd0, uni_count}, 5);
    chk("t1_gen_before", {22'd0, gen_count}, 3);
    chk("t1_hour_before", {27'd0, hour}, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_gate", {31'd0, gate_open}, 0);
    chk("t1_uni", {22'd0, uni_count}, 0);
    chk("t1_gen", {22'd0, gen_count}, 0);
    chk("t1_hour", {27'd0, hour}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // single entry latency and barrier width
    lanes.ent_req = 1'b1; lanes.ent_is_uni = 1'b1;
    wait_ack(ea, eg, xa, cyc);
    lanes.ent_req = 1'b0;
    chk("t6_latency", cyc, 2);
    chk("t6_grant", {31'd0, eg}, 1);
    chk("t6_gate_at_ack", {31'd0, gate_open}, 1);
    @(negedge clk);
    chk("t6_ack_pulse", {31'd0, lanes.ent_ack}, 0);
    chk("t6_grant_low", {31'd0, lanes.ent_grant}, 0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (!gate_open) break;
      n++;
      @(negedge clk);
    end
    chk("t6_open_cycles", n, 4);

    // exit from empty general class
    lanes.ext_req = 1'b1; lanes.ext_is_uni = 1'b0;
    wait_ack(ea, eg, xa, cyc);
    lanes.ext_req = 1'b0;
    chk("t5_ext_ack", {31'd0, xa}, 1);
    chk("t5_gen", {22'd0, gen_count}, 0);
    chk("t5_gate", {31'd0, gate_open}, 0);
    @(negedge clk);
    chk("t5_gate_after", {31'd0, gate_open}, 0);

    // fill uni at hour 10
    repeat (10) tick();
    chk("t2_hour", {27'd0, hour}, 10);
    n = 0;
    for (int i = 0; i < 499; i++) begin serve(1, 1, g); n += int'(g); end
    chk("t2_grants", n, 499);
    chk("t2_uni", {22'd0, uni_count}, 500);
    chk("t2_full", {31'd0, uni_full}, 1);
    lanes.ent_req = 1'b1; lanes.ent_is_uni = 1'b1;
    wait_ack(ea, eg, xa, cyc);
    lanes.ent_req = 1'b0;
    chk("t2_501_ack", {31'd0, ea}, 1);
    chk("t2_501_grant", {31'd0, eg}, 0);
    chk("t2_501_gate", {31'd0, gate_open}, 0);
    @(negedge clk);
    chk("t2_uni_hold", {22'd0, uni_count}, 500);

    // capacity shrink below count
    repeat (2) tick();
    for (int i = 0; i < 80; i++) serve(0, 1, g);
    chk("t3_uni420", {22'd0, uni_count}, 420);
    chk("t3_notfull12", {31'd0, uni_full}, 0);
    repeat (2) tick();
    chk("t3_hour14", {27'd0, hour}, 14);
    chk("t3_full14", {31'd0, uni_full}, 1);
    chk("t3_genfull14", {31'd0, gen_full}, 0);
    serve(1, 1, g);
    chk("t3_refused", {31'd0, g}, 0);
    for (int i = 0; i < 21; i++) serve(0, 1, g);
    chk("t3_uni399", {22'd0, uni_count}, 399);
    chk("t3_notfull", {31'd0, uni_full}, 0);
    serve(1, 1, g);
    chk("t3_admitted", {31'd0, g}, 1);
    chk("t3_uni400", {22'd0, uni_count}, 400);

    // simultaneous requests, round-robin
    serve(0, 0, g);
    lanes.ent_req = 1'b1; lanes.ent_is_uni = 1'b0;
    lanes.ext_req = 1'b1; lanes.ext_is_uni = 1'b1;
    wait_ack(ea, eg, xa, cyc);
    chk("t4_first_ent", {31'd0, ea}, 1);
    chk("t4_first_noext", {31'd0, xa}, 0);
    chk("t4_first_grant", {31'd0, eg}, 1);
    wait_ack(ea, eg, xa, cyc);
    lanes.ext_req = 1'b0;
    chk("t4_second_ext", {31'd0, xa}, 1);
    chk("t4_second_noent", {31'd0, ea}, 0);
    wait_ack(ea, eg, xa, cyc);
    lanes.ent_req = 1'b0;
    chk("t4_third_ent", {31'd0, ea}, 1);
    wait_closed();
    chk("t4_uni", {22'd0, uni_count}, 399);
    chk("t4_gen", {22'd0, gen_count}, 2);

    // late-day capacity and hour wrap
    repeat (2) tick();
    chk("h16_unifull", {31'd0, uni_full}, 1);
    chk("h16_genfull", {31'd0, gen_full}, 0);
    repeat (7) tick();
    chk("h23", {27'd0, hour}, 23);
    tick();
    chk("h_wrap", {27'd0, hour}, 0);
    chk("h0_unifull", {31'd0, uni_full}, 0);
`ifdef PARK_REJECT_STATS_EN
    chk("reject_count", {16'd0, reject_count}, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
